// File: rtl/disp_pkg.sv
// disp_pkg: shared seven-segment types, constants and BCD pattern table
package disp_pkg;
  typedef logic [7:0] seg_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] BCD_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };
endpackage

// File: rtl/bcd_to_sseg.sv
// bcd_to_sseg: active-low segment decode, dash for non-decimal codes
module bcd_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  assign o_seg = BCD_PAT[i_bcd];
endmodule

// File: rtl/freq_disp_mux.sv
// freq_disp_mux: multiplexed 4-digit display with zero blanking, dp and anti-ghost gap
module freq_disp_mux
  import disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] bcd_in [3:0],
  input  logic [3:0] autoscale,
  output logic [3:0] an,
  output seg_t       seg
);
  localparam logic [REFRESH_BITS-1:0] ONE = 1;
  localparam logic [REFRESH_BITS-3:0] BLANK_L = BLANK_CYCLES[REFRESH_BITS-3:0];
  logic [REFRESH_BITS-1:0] r_cnt;
  logic [3:0] r_dig [3:0];
  logic [3:0] r_dp;
  logic [3:0] r_an;
  seg_t r_seg;
  logic [1:0] w_sel;
  logic [3:0] w_zero;
  logic [6:0] w_dec;
  logic w_dp_on;
  logic w_lz;
  logic w_gap;
  assign w_sel = r_cnt[REFRESH_BITS-1 -: 2];
  assign w_gap = r_cnt[REFRESH_BITS-3:0] < BLANK_L;
  assign w_zero[3] = r_dig[3] == 4'd0;
  assign w_zero[2] = w_zero[3] && r_dig[2] == 4'd0;
  assign w_zero[1] = w_zero[2] && r_dig[1] == 4'd0;
  assign w_zero[0] = w_zero[1] && r_dig[0] == 4'd0;
  assign w_dp_on = r_dp <= 4'd3 && r_dp[1:0] == w_sel;
  assign w_lz = w_sel != 2'd0 && (r_dp > 4'd3 || {2'b00, w_sel} > r_dp) && w_zero[w_sel];
  assign an = r_an;
  assign seg = r_seg;
  bcd_to_sseg u_dec (
    .i_bcd(r_dig[w_sel]),
    .o_seg(w_dec)
  );
  // Scan counter and shadow copy of the last loaded result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dig <= '{default: 4'h0};
      r_dp <= 4'hF;
    end else begin
      r_cnt <= r_cnt + ONE;
      if (load) begin
        r_dig <= bcd_in;
        r_dp <= autoscale;
      end
    end
  end
  // Registered pin drive; anodes held off during the start-of-slot gap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an <= 4'hF;
      r_seg <= 8'hFF;
    end else begin
      r_an <= w_gap ? 4'hF : ~(4'b0001 << w_sel);
      r_seg <= {~w_dp_on, w_lz ? SEG_BLANK : w_dec};
    end
  end
endmodule

// File: tb/tb_freq_disp_mux.sv
// tb_freq_disp_mux: randomized and directed checks against a digit-level display model
module tb_freq_disp_mux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [3:0] bcd [3:0];
  logic [3:0] autoscale = 4'h0;
  logic [3:0] an;
  logic [7:0] seg;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  int m_dig [4] = '{0, 0, 0, 0};
  int m_dp = 15;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  int e_sel;
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  freq_disp_mux #(.REFRESH_BITS(6), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .bcd_in(bcd),
    .autoscale(autoscale),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic model_expect();
    int above;
    bit lz;
    e_sel = m_cnt / 16;
    e_an = 4'hF;
    if (m_cnt % 16 >= 2) e_an[e_sel] = 1'b0;
    above = 0;
    for (int j = e_sel; j < 4; j++) above += m_dig[j];
    lz = e_sel > 0 && (m_dp > 3 || e_sel > m_dp) && above == 0;
    e_seg[6:0] = lz ? 7'h7F : pat[m_dig[e_sel]];
    e_seg[7] = !(m_dp <= 3 && m_dp == e_sel);
  endtask

  task automatic tick(input bit rst, input bit ld, input int d3, d2, d1, d0, input int as);
    reset = rst;
    load = ld;
    bcd[3] = 4'(d3);
    bcd[2] = 4'(d2);
    bcd[1] = 4'(d1);
    bcd[0] = 4'(d0);
    autoscale = 4'(as);
    model_expect();
    if (rst) begin
      e_an = 4'hF;
      e_seg = 8'hFF;
    end
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_dig = '{0, 0, 0, 0};
      m_dp = 15;
    end else begin
      m_cnt = (m_cnt + 1) % 64;
      if (ld) begin
        m_dig[3] = d3;
        m_dig[2] = d2;
        m_dig[1] = d1;
        m_dig[0] = d0;
        m_dp = as;
      end
    end
    #1;
    reset = 1'b0;
    load = 1'b0;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL reset_an got %h want f", an);
    end
    checks++;
    if (seg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_seg got %h want ff", seg);
    end
  endtask

  task automatic test_idle_scan();
    int gaps = 0;
    for (int c = 0; c < 64; c++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      if (an === 4'hF) gaps++;
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        errors++;
        $display("FAIL idle_scan c=%0d got an=%h seg=%h want an=%h seg=%h", c, an, seg, e_an, e_seg);
      end
      if (e_an != 4'hF) begin
        checks++;
        if (seg !== (e_sel == 0 ? 8'hC0 : 8'hFF)) begin
          errors++;
          $display("FAIL idle_digit sel=%0d got %h", e_sel, seg);
        end
      end
    end
    checks++;
    if (gaps != 8) begin
      errors++;
      $display("FAIL idle_gap_count got %0d want 8", gaps);
    end
  endtask

  task automatic test_pattern(input string name, input int d3, d2, d1, d0, input int as,
                              input logic [7:0] s3, s2, s1, s0);
    logic [7:0] ds [4];
    ds[3] = s3;
    ds[2] = s2;
    ds[1] = s1;
    ds[0] = s0;
    tick(0, 1, d3, d2, d1, d0, as);
    checks++;
    if (an !== e_an || seg !== e_seg) begin
      errors++;
      $display("FAIL %s load_edge got an=%h seg=%h want an=%h seg=%h", name, an, seg, e_an, e_seg);
    end
    for (int c = 0; c < 64; c++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        errors++;
        $display("FAIL %s model c=%0d got an=%h seg=%h want an=%h seg=%h", name, c, an, seg, e_an, e_seg);
      end
      if (e_an != 4'hF) begin
        checks++;
        if (seg !== ds[e_sel]) begin
          errors++;
          $display("FAIL %s digit%0d got %h want %h", name, e_sel, seg, ds[e_sel]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int d [4];
      for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 15)) : 0;
      tick(0, $urandom_range(0, 7) == 0, d[3], d[2], d[1], d[0], $urandom_range(0, 7));
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        errors++;
        $display("FAIL random c=%0d got an=%h seg=%h want an=%h seg=%h", c, an, seg, e_an, e_seg);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    tick(0, 1, 7, 3, 1, 4, 1);
    for (int c = 0; c < 21; c++) tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 9, 9, 9, 9, 1);
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_scan got an=%h seg=%h want an=f seg=ff", an, seg);
    end
    for (int c = 0; c < 64; c++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (an !== e_an || seg !== e_seg) begin
        errors++;
        $display("FAIL post_reset c=%0d got an=%h seg=%h want an=%h seg=%h", c, an, seg, e_an, e_seg);
      end
      if (e_an != 4'hF) begin
        checks++;
        if (seg !== (e_sel == 0 ? 8'hC0 : 8'hFF)) begin
          errors++;
          $display("FAIL post_reset_digit sel=%0d got %h", e_sel, seg);
        end
      end
    end
  endtask

  initial begin
    bcd[3] = 4'h0;
    bcd[2] = 4'h0;
    bcd[1] = 4'h0;
    bcd[0] = 4'h0;
    test_reset();
    test_idle_scan();
    test_pattern("ascending", 3, 2, 1, 0, 4, 8'hB0, 8'hA4, 8'hF9, 8'hC0);
    test_pattern("dp2", 0, 0, 8, 5, 2, 8'hFF, 8'h40, 8'h80, 8'h92);
    test_pattern("zeros_dp0", 0, 0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'h40);
    test_pattern("dash", 0, 12, 0, 0, 7, 8'hFF, 8'hBF, 8'hC0, 8'hC0);
    test_random();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
